// File: rtl/agc_mon_pkg.sv
// ---------------------------------------------------------------------------
// agc_mon_pkg
// Shared definitions for the AGC timepulse monitor: tracker state encoding,
// timepulse count, nominal pulse length, and small helpers for one-hot
// timepulse vectors.
// ---------------------------------------------------------------------------
package agc_mon_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } mon_state_e;

  localparam int TP_COUNT          = 12;
  localparam int NOMINAL_TP_CYCLES = 50;

  // Number of set bits in a timepulse vector (0..12 fits in 4 bits).
  function automatic logic [3:0] tp_popcount(input logic [TP_COUNT-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < TP_COUNT; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // Successor pulse index in the T01..T12 ring.
  function automatic logic [3:0] tp_next(input logic [3:0] idx);
    return (idx == 4'(TP_COUNT)) ? 4'd1 : idx + 4'd1;
  endfunction

endpackage

// File: rtl/agc_sync_edge.sv
// ---------------------------------------------------------------------------
// agc_sync_edge
// Multi-bit synchroniser followed by a rising-edge detector.
//   i_clk    in   1   sampling clock
//   i_rst    in   1   asynchronous active-high reset (clears all flops)
//   i_d      in   W   asynchronous input lines
//   o_sync   out  W   synchronised level (after SYNC_STAGES flops)
//   o_rise   out  W   one-cycle rising-edge flags on the synchronised level
// SYNC_STAGES = 0 passes i_d straight through (inputs already in clock domain).
// ---------------------------------------------------------------------------
module agc_sync_edge
  import agc_mon_pkg::*;
#(
  parameter int W           = TP_COUNT + 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_sync,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_prev;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign o_sync = i_d;
    end else begin : g_sync
      logic [W-1:0] r_sync [SYNC_STAGES];

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            r_sync[i] <= '0;
          end
        end else begin
          r_sync[0] <= i_d;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
          end
        end
      end

      assign o_sync = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // Edge-detect stage
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev <= '0;
    end else begin
      r_prev <= o_sync;
    end
  end

  assign o_rise = o_sync & ~r_prev;

endmodule

// File: rtl/agc_timepulse_monitor.sv
// ---------------------------------------------------------------------------
// agc_timepulse_monitor
// Checks the AGC monitor timepulses MT01..MT12: follows the T01->T12 ring,
// declares lock after LOCK_MCTS clean MCTs, and counts sequence, overlap,
// stall and MGOJAM events for host readout.
//   SIM_CLK            in   1      51.2 MHz system clock
//   SIM_RST            in   1      asynchronous active-high reset
//   MT                 in   12     timepulses, bit 0 = MT01
//   MGOJAM             in   1      GOJAM monitor line
//   clr_stats          in   1      synchronous clear of all counters
//   tp_index           out  4      last valid pulse 1..12 while locked, else 0
//   locked             out  1      sequence lock
//   mct_strobe         out  1      one-cycle pulse per T01 while locked
//   mct_count          out  16     MCTs while locked (wraps)
//   seq_err_count      out  CNT_W  out-of-order edges (saturating)
//   overlap_err_count  out  CNT_W  cycles with >1 MT high (saturating)
//   stall_err_count    out  CNT_W  stall timeouts (saturating)
//   gojam_count        out  CNT_W  MGOJAM rising edges (saturating)
// ---------------------------------------------------------------------------
module agc_timepulse_monitor
  import agc_mon_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int STALL_CYCLES = 256,
  parameter int LOCK_MCTS    = 2,
  parameter int CNT_W        = 8
) (
  input  logic                SIM_CLK,
  input  logic                SIM_RST,
  input  logic [TP_COUNT-1:0] MT,
  input  logic                MGOJAM,
  input  logic                clr_stats,
  output logic [3:0]          tp_index,
  output logic                locked,
  output logic                mct_strobe,
  output logic [15:0]         mct_count,
  output logic [CNT_W-1:0]    seq_err_count,
  output logic [CNT_W-1:0]    overlap_err_count,
  output logic [CNT_W-1:0]    stall_err_count,
  output logic [CNT_W-1:0]    gojam_count
);

  localparam int TMR_W  = $clog2(STALL_CYCLES + 1);
  localparam int GOOD_W = (LOCK_MCTS < 2) ? 1 : $clog2(LOCK_MCTS + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [TP_COUNT:0]   w_sync;
  logic [TP_COUNT:0]   w_rise;
  logic [TP_COUNT-1:0] w_mt_sync;
  logic [TP_COUNT-1:0] w_mt_rise;
  logic                w_gojam_rise;
  logic                w_unused_gojam_lvl;

  logic [3:0] w_high_cnt;
  logic [3:0] w_rise_cnt;
  logic [3:0] w_idx;
  logic       w_overlap;
  logic       w_edge;
  logic       w_any_rise;
  logic       w_tracking;
  logic       w_seq_err;
  logic       w_stall_err;
  logic       w_break;
  logic       w_valid_edge;
  logic       w_lock_done;
  logic       w_mct_evt;

  mon_state_e r_state;
  mon_state_e w_nstate;

  logic [3:0]       r_expected;
  logic [3:0]       r_tp;
  logic [GOOD_W-1:0] r_good;
  logic [TMR_W-1:0] r_stall_tmr;
  logic             r_mct_strobe;
  logic [15:0]      r_mct_count;
  logic [CNT_W-1:0] r_seq_cnt;
  logic [CNT_W-1:0] r_ovl_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_gojam_cnt;

  // Synchroniser + edge detect for {MGOJAM, MT}
  agc_sync_edge #(
    .W           (TP_COUNT + 1),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .i_clk  (SIM_CLK),
    .i_rst  (SIM_RST),
    .i_d    ({MGOJAM, MT}),
    .o_sync (w_sync),
    .o_rise (w_rise)
  );

  assign w_mt_sync          = w_sync[TP_COUNT-1:0];
  assign w_mt_rise          = w_rise[TP_COUNT-1:0];
  assign w_gojam_rise       = w_rise[TP_COUNT];
  // Only GOJAM edges matter; its level is not used.
  assign w_unused_gojam_lvl = w_sync[TP_COUNT];

  // Event classification on the synchronised lines
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < TP_COUNT; i++) begin
      if (w_mt_rise[i]) w_idx = 4'(i + 1);
    end
  end

  assign w_high_cnt = tp_popcount(w_mt_sync);
  assign w_rise_cnt = tp_popcount(w_mt_rise);
  assign w_overlap  = (w_high_cnt > 4'd1);
  assign w_edge     = (w_rise_cnt == 4'd1);
  assign w_any_rise = |w_mt_rise;
  assign w_tracking = (r_state != HUNT);

  // An overlap cycle is reported only as an overlap, never also as a
  // sequence or stall error.
  assign w_seq_err   = w_tracking && w_edge && !w_overlap && (w_idx != r_expected);
  assign w_stall_err = w_tracking && !w_any_rise && !w_overlap &&
                       (r_stall_tmr == TMR_W'(STALL_CYCLES - 1));
  assign w_break     = w_tracking && (w_overlap || w_seq_err || w_stall_err);

  // HUNT only accepts MT01; TRACK/LOCKED accept the expected successor.
  assign w_valid_edge = w_edge && !w_overlap &&
                        (w_tracking ? (w_idx == r_expected) : (w_idx == 4'd1));
  assign w_lock_done  = (r_good == GOOD_W'(LOCK_MCTS - 1));

  // State register
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_nstate;
    end
  end

  // Next-state logic
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      HUNT: begin
        if (w_valid_edge) w_nstate = TRACK;
      end
      TRACK: begin
        if (w_break) begin
          w_nstate = HUNT;
        end else if (w_valid_edge && (w_idx == 4'd1) && w_lock_done) begin
          w_nstate = LOCKED;
        end
      end
      LOCKED: begin
        if (w_break) w_nstate = HUNT;
      end
      default: w_nstate = HUNT;
    endcase
  end

  // Output decode
  always_comb begin
    locked   = (r_state == LOCKED);
    tp_index = (r_state == LOCKED) ? r_tp : 4'd0;
  end

  // The T01 edge that completes lock acquisition is already the first
  // strobed MCT.
  assign w_mct_evt = w_valid_edge && (w_idx == 4'd1) && (w_nstate == LOCKED);

  // Tracker datapath: expected pulse, clean-MCT count, stall timer
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      r_expected   <= 4'd2;
      r_good       <= '0;
      r_tp         <= '0;
      r_stall_tmr  <= '0;
      r_mct_strobe <= 1'b0;
    end else begin
      if (!w_tracking || w_any_rise) begin
        r_stall_tmr <= '0;
      end else if (r_stall_tmr != TMR_W'(STALL_CYCLES)) begin
        r_stall_tmr <= r_stall_tmr + 1'b1;
      end

      if (!w_tracking) begin
        r_expected <= 4'd2;
        r_good     <= '0;
      end else if (w_valid_edge) begin
        r_expected <= tp_next(w_idx);
        if ((w_idx == 4'd1) && (r_state == TRACK)) begin
          r_good <= r_good + 1'b1;
        end
      end

      if (w_valid_edge) r_tp <= w_idx;
      r_mct_strobe <= w_mct_evt;
    end
  end

  // Statistics counters; clear has priority over a same-cycle increment
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      r_mct_count <= '0;
      r_seq_cnt   <= '0;
      r_ovl_cnt   <= '0;
      r_stall_cnt <= '0;
      r_gojam_cnt <= '0;
    end else if (clr_stats) begin
      r_mct_count <= '0;
      r_seq_cnt   <= '0;
      r_ovl_cnt   <= '0;
      r_stall_cnt <= '0;
      r_gojam_cnt <= '0;
    end else begin
      if (w_mct_evt)    r_mct_count <= r_mct_count + 16'd1;
      if (w_seq_err)    r_seq_cnt   <= sat_inc(r_seq_cnt);
      if (w_overlap)    r_ovl_cnt   <= sat_inc(r_ovl_cnt);
      if (w_stall_err)  r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_gojam_rise) r_gojam_cnt <= sat_inc(r_gojam_cnt);
    end
  end

  assign mct_strobe        = r_mct_strobe;
  assign mct_count         = r_mct_count;
  assign seq_err_count     = r_seq_cnt;
  assign overlap_err_count = r_ovl_cnt;
  assign stall_err_count   = r_stall_cnt;
  assign gojam_count       = r_gojam_cnt;

endmodule

// File: tb/tb_agc_timepulse_monitor.sv
// ---------------------------------------------------------------------------
// tb_agc_timepulse_monitor
// Directed bench for agc_timepulse_monitor with a behavioural reference
// model and literal checkpoints.
// ---------------------------------------------------------------------------
module tb_agc_timepulse_monitor;
  import agc_mon_pkg::*;

  localparam int SS    = 2;
  localparam int STALL = 256;
  localparam int LOCKN = 2;
  localparam int CW    = 8;
  localparam int TP    = NOMINAL_TP_CYCLES;
  localparam int CMAX  = (1 << CW) - 1;

  logic          SIM_CLK   = 1'b0;
  logic          SIM_RST   = 1'b0;
  logic [11:0]   MT        = '0;
  logic          MGOJAM    = 1'b0;
  logic          clr_stats = 1'b0;
  logic [3:0]    tp_index;
  logic          locked;
  logic          mct_strobe;
  logic [15:0]   mct_count;
  logic [CW-1:0] seq_err_count;
  logic [CW-1:0] overlap_err_count;
  logic [CW-1:0] stall_err_count;
  logic [CW-1:0] gojam_count;

  agc_timepulse_monitor #(
    .SYNC_STAGES  (SS),
    .STALL_CYCLES (STALL),
    .LOCK_MCTS    (LOCKN),
    .CNT_W        (CW)
  ) dut (
    .SIM_CLK           (SIM_CLK),
    .SIM_RST           (SIM_RST),
    .MT                (MT),
    .MGOJAM            (MGOJAM),
    .clr_stats         (clr_stats),
    .tp_index          (tp_index),
    .locked            (locked),
    .mct_strobe        (mct_strobe),
    .mct_count         (mct_count),
    .seq_err_count     (seq_err_count),
    .overlap_err_count (overlap_err_count),
    .stall_err_count   (stall_err_count),
    .gojam_count       (gojam_count)
  );

  always #10 SIM_CLK = ~SIM_CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Reference model: sees each input sample SS clocks late and applies the
  // pulse-ring rules directly on whole vectors.
  logic [12:0] hist [0:SS+1];
  logic [12:0] cur, prv, rise;
  int nhigh, nrise, idx;
  bit bad;
  int m_hunting = 1, m_last = 0, m_clean = 0, m_since = 0, m_lock = 0;
  int m_strobe = 0, m_mct = 0, m_seq = 0, m_ovl = 0, m_stall = 0, m_gj = 0;

  always @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      for (int k = 0; k <= SS + 1; k++) hist[k] = '0;
      m_hunting = 1; m_last = 0; m_clean = 0; m_since = 0; m_lock = 0;
      m_strobe = 0; m_mct = 0; m_seq = 0; m_ovl = 0; m_stall = 0; m_gj = 0;
    end else begin
      for (int k = SS + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = {MGOJAM, MT};
      cur   = hist[SS];
      prv   = hist[SS+1];
      rise  = cur & ~prv;
      nhigh = $countones(cur[11:0]);
      nrise = $countones(rise[11:0]);
      idx   = 0;
      for (int b = 0; b < 12; b++) if (rise[b]) idx = b + 1;
      m_strobe = 0;
      if (nhigh > 1) m_ovl = sat(m_ovl);
      if (rise[12]) m_gj = sat(m_gj);
      if (m_hunting != 0) begin
        if (nrise == 1 && idx == 1 && nhigh <= 1) begin
          m_hunting = 0; m_last = 1; m_clean = 0; m_since = 0;
        end
      end else begin
        bad = 0;
        if (nrise > 0) m_since = 0; else m_since++;
        if (nhigh > 1) bad = 1;
        else if (nrise == 1 && idx != (m_last % 12) + 1) begin
          m_seq = sat(m_seq); bad = 1;
        end else if (nrise == 0 && m_since == STALL) begin
          m_stall = sat(m_stall); bad = 1;
        end
        if (bad) begin
          m_hunting = 1; m_lock = 0;
        end else if (nrise == 1) begin
          m_last = idx;
          if (idx == 1) begin
            if (m_lock == 0) begin
              m_clean++;
              if (m_clean == LOCKN) m_lock = 1;
            end
            if (m_lock != 0) begin
              m_strobe = 1;
              m_mct = (m_mct + 1) % 65536;
            end
          end
        end
      end
      if (clr_stats) begin
        m_mct = 0; m_seq = 0; m_ovl = 0; m_stall = 0; m_gj = 0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge SIM_CLK) begin
    if (!SIM_RST) begin
      chk("locked", int'(locked), m_lock);
      chk("tp_index", int'(tp_index), (m_lock != 0) ? m_last : 0);
      chk("mct_strobe", int'(mct_strobe), m_strobe);
      chk("mct_count", int'(mct_count), m_mct);
      chk("seq_err_count", int'(seq_err_count), m_seq);
      chk("overlap_err_count", int'(overlap_err_count), m_ovl);
      chk("stall_err_count", int'(stall_err_count), m_stall);
      chk("gojam_count", int'(gojam_count), m_gj);
    end
  end

  task automatic step();
    @(posedge SIM_CLK);
    #1;
  endtask

  task automatic pulse(input int tp, input int n);
    MT = 12'(1 << (tp - 1));
    repeat (n) step();
  endtask

  task automatic mct_run(input int first, input int last);
    for (int i = first; i <= last; i++) pulse(i, TP);
  endtask

  initial begin
    SIM_RST = 1'b1;
    repeat (3) @(posedge SIM_CLK);
    #1;
    chk("reset locked", int'(locked), 0);
    chk("reset tp_index", int'(tp_index), 0);
    chk("reset mct_count", int'(mct_count), 0);
    chk("reset seq", int'(seq_err_count), 0);
    chk("reset gojam", int'(gojam_count), 0);
    SIM_RST = 1'b0;

    // Clean acquisition: lock on the third MT01 edge
    mct_run(1, 12);
    mct_run(1, 12);
    pulse(1, 2);
    chk("lock latency-1", int'(locked), 0);
    step();
    chk("lock rise", int'(locked), 1);
    chk("first strobe", int'(mct_strobe), 1);
    chk("first mct_count", int'(mct_count), 1);
    chk("lock tp_index", int'(tp_index), 1);
    repeat (TP - 3) step();
    mct_run(2, 6);
    chk("tp_index at MT06", int'(tp_index), 6);
    chk("clean seq", int'(seq_err_count), 0);
    chk("clean overlap", int'(overlap_err_count), 0);
    chk("clean stall", int'(stall_err_count), 0);

    // Skip MT07
    pulse(8, 2);
    chk("skip latency-1 locked", int'(locked), 1);
    step();
    chk("skip seq", int'(seq_err_count), 1);
    chk("skip locked", int'(locked), 0);
    chk("skip tp_index", int'(tp_index), 0);
    repeat (TP - 3) step();
    mct_run(9, 12);
    mct_run(1, 12);
    mct_run(1, 12);
    pulse(1, 3);
    chk("relock", int'(locked), 1);
    chk("relock mct_count", int'(mct_count), 2);
    repeat (TP - 3) step();

    // MT03/MT04 overlap for one cycle
    mct_run(2, 2);
    pulse(3, TP - 1);
    MT = 12'b0000_0000_1100;
    step();
    pulse(4, TP);
    chk("overlap count", int'(overlap_err_count), 1);
    chk("overlap no seq", int'(seq_err_count), 1);
    chk("overlap locked", int'(locked), 0);
    mct_run(5, 12);

    // Stall on MT05
    mct_run(1, 4);
    pulse(5, 258);
    chk("stall before timeout", int'(stall_err_count), 0);
    step();
    chk("stall at timeout", int'(stall_err_count), 1);
    repeat (41) step();
    chk("stall held", int'(stall_err_count), 1);
    mct_run(6, 12);
    mct_run(1, 12);
    mct_run(1, 12);
    pulse(1, TP);
    chk("relock after stall", int'(locked), 1);
    chk("mct_count before clear", int'(mct_count), 3);

    // GOJAM pulses while locked
    MT = 12'(1 << 1);
    for (int g = 0; g < 3; g++) begin
      MGOJAM = 1'b1;
      repeat (5) step();
      MGOJAM = 1'b0;
      repeat (5) step();
    end
    repeat (TP - 30) step();
    chk("gojam count", int'(gojam_count), 3);
    chk("gojam keeps lock", int'(locked), 1);
    mct_run(3, 12);

    // clr_stats lands in the same cycle as the internal MT01 edge
    pulse(1, 2);
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    chk("clr mct_count", int'(mct_count), 0);
    chk("clr gojam", int'(gojam_count), 0);
    chk("clr overlap", int'(overlap_err_count), 0);
    chk("clr seq", int'(seq_err_count), 0);
    chk("clr stall", int'(stall_err_count), 0);
    chk("clr keeps lock", int'(locked), 1);
    chk("clr strobe", int'(mct_strobe), 1);
    repeat (TP - 3) step();

    // Asynchronous reset in the middle of MT09
    mct_run(2, 4);
    MT = 12'(1 << 4);
    MGOJAM = 1'b1;
    repeat (5) step();
    MGOJAM = 1'b0;
    repeat (TP - 5) step();
    mct_run(6, 8);
    pulse(9, 20);
    chk("pre-reset tp_index", int'(tp_index), 9);
    chk("pre-reset gojam", int'(gojam_count), 1);
    #3;
    SIM_RST = 1'b1;
    #1;
    chk("async rst locked", int'(locked), 0);
    chk("async rst tp_index", int'(tp_index), 0);
    chk("async rst gojam", int'(gojam_count), 0);
    chk("async rst strobe", int'(mct_strobe), 0);
    repeat (2) @(posedge SIM_CLK);
    #1;
    SIM_RST = 1'b0;
    repeat (28) step();
    mct_run(10, 12);
    mct_run(1, 12);
    pulse(1, 3);
    chk("no early relock", int'(locked), 0);
    repeat (TP - 3) step();
    mct_run(2, 12);
    pulse(1, 3);
    chk("relock after reset", int'(locked), 1);
    chk("mct_count after reset", int'(mct_count), 1);
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
